// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: RGB565 test-pattern source for the LCD output path.
// Takes DE/HSYNC/VSYNC from the timing generator, tracks x/y inside the
// active area and renders bars, checker, gradient or a solid colour.
// Two pix_ce-qualified pipeline stages; syncs travel alongside the pixel.
`timescale 1ns/1ps

module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE = 480,   // active pixels per line, multiple of 8
  parameter int unsigned V_ACTIVE = 272,   // active lines per frame
  parameter logic        SYNC_POL = 1'b0   // asserted sync level (0 = active-low)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic        de_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic [4:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [4:0]  lcd_b,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [7:0]  frame_cnt
);

  // Width of one colour bar: eight equal bars across the active line.
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  // Counters hold 10-bit x and 9-bit y, so the geometry has to fit them.
  if (((H_ACTIVE % 8) != 0) || (H_ACTIVE > 1024) || (V_ACTIVE > 512)) begin : g_bad_geometry
    $error("lcd_pattern_gen: unsupported H_ACTIVE/V_ACTIVE");
  end

  // ---------------------------------------------------------------------
  // Position / frame state
  // ---------------------------------------------------------------------
  logic [9:0]  r_x;          // x of the pixel currently on de_in
  logic [8:0]  r_y;          // y of the line currently on de_in
  logic [1:0]  r_mode;       // pattern select, latched once per frame
  logic [7:0]  r_frame_cnt;

  // ---------------------------------------------------------------------
  // Stage 1: registered inputs plus per-pattern decode
  // ---------------------------------------------------------------------
  logic        r_de1;
  logic        r_hs1;
  logic        r_vs1;
  logic [15:0] r_bar_rgb1;   // bar colour for this pixel
  logic        r_chk1;       // checker cell is white
  logic [4:0]  r_grad_r1;    // gradient red   = x[8:4]
  logic [5:0]  r_grad_g1;    // gradient green = y[8:3]
  logic [15:0] r_solid1;

  // ---------------------------------------------------------------------
  // Stage 2: final colour and delayed syncs
  // ---------------------------------------------------------------------
  logic        r_de2;
  logic        r_hs2;
  logic        r_vs2;
  logic [15:0] r_rgb2;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic        w_de_fall;    // end of an active line
  logic        w_vs_rise;    // start of a frame (vsync just asserted)
  logic [9:0]  w_x_inc;      // saturating x + 1
  logic [9:0]  w_bar_full;   // x / BAR_W before clamping
  logic [2:0]  w_bar;        // bar index, clamped to black past the line
  logic [15:0] w_bar_pal [8];
  logic [15:0] w_colour;

  // The edge detectors compare the live input against its stage-1 copy,
  // which is exactly the previous pix_ce sample.
  assign w_de_fall  = r_de1 & ~de_in;
  assign w_vs_rise  = (vsync_in == SYNC_POL) && (r_vs1 != SYNC_POL);
  assign w_x_inc    = (r_x == 10'd1023) ? r_x : r_x + 10'd1;

  // Overlong DE lines run past bar 7; keep them black rather than wrapping.
  assign w_bar_full = r_x / 10'(BAR_W);
  assign w_bar      = (w_bar_full > 10'd7) ? 3'd7 : w_bar_full[2:0];

  // Bar palette: white, yellow, cyan, green, magenta, red, blue, black.
  // Index bit 1 kills red, bit 2 kills green, bit 0 kills blue.
  for (genvar gi = 0; gi < 8; gi++) begin : g_bar_pal
    localparam logic [2:0] IDX = 3'(gi);
    assign w_bar_pal[gi] = {{5{~IDX[1]}}, {6{~IDX[2]}}, {5{~IDX[0]}}};
  end

  // x/y tracking, per-frame mode latch and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= '0;
      r_frame_cnt <= '0;
    end else if (pix_ce) begin
      if (de_in) begin
        r_x <= w_x_inc;
      end else if (w_de_fall) begin
        r_x <= '0;
      end

      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall && (r_y != 9'd511)) begin
        r_y <= r_y + 9'd1;
      end

      // Mode only changes on a frame boundary so a frame is never mixed.
      if (w_vs_rise) begin
        r_mode      <= mode;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  // Stage 1: capture syncs and pre-decode every pattern for this pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de1      <= 1'b0;
      r_hs1      <= ~SYNC_POL;
      r_vs1      <= ~SYNC_POL;
      r_bar_rgb1 <= '0;
      r_chk1     <= 1'b0;
      r_grad_r1  <= '0;
      r_grad_g1  <= '0;
      r_solid1   <= '0;
    end else if (pix_ce) begin
      r_de1      <= de_in;
      r_hs1      <= hsync_in;
      r_vs1      <= vsync_in;
      r_bar_rgb1 <= w_bar_pal[w_bar];
      r_chk1     <= r_x[4] ^ r_y[4];
      r_grad_r1  <= r_x[8:4];
      r_grad_g1  <= r_y[8:3];
      r_solid1   <= solid_rgb;
    end
  end

  // Pick the pattern for the stage-1 pixel; blank outside the active area.
  always_comb begin
    w_colour = 16'h0000;
    if (r_de1) begin
      case (r_mode)
        2'd0:    w_colour = r_bar_rgb1;
        2'd1:    w_colour = r_chk1 ? 16'hFFFF : 16'h0000;
        2'd2:    w_colour = {r_grad_r1, r_grad_g1, r_frame_cnt[4:0]};
        default: w_colour = r_solid1;
      endcase
    end
  end

  // Stage 2: register the colour and the second sync delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_de2  <= 1'b0;
      r_hs2  <= ~SYNC_POL;
      r_vs2  <= ~SYNC_POL;
      r_rgb2 <= '0;
    end else if (pix_ce) begin
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_rgb2 <= w_colour;
    end
  end

  assign lcd_r     = r_rgb2[15:11];
  assign lcd_g     = r_rgb2[10:5];
  assign lcd_b     = r_rgb2[4:0];
  assign de_out    = r_de2;
  assign hsync_out = r_hs2;
  assign vsync_out = r_vs2;
  assign frame_cnt = r_frame_cnt;

endmodule
